// File: rtl/bus_timer_pkg.sv
// rtl/bus_timer_pkg.sv - shared register offsets, state/mode codes and byte-lane merge for bus_timer
//
// Purpose: definitions shared by the bus_timer block.
//   TMR_CTRL/TMR_PRESET/TMR_COUNT : register word offsets (addr[3:2])
//   tmr_state_e                   : timer FSM states (IDLE, LOAD, CNT, INT)
//   TMR_ONESHOT/TMR_RELOAD        : CTRL.MODE codes
//   lane_merge()                  : per-byte write merge driven by byte enables
package bus_timer_pkg;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_LOAD = 2'd1,
    TMR_CNT  = 2'd2,
    TMR_INT  = 2'd3
  } tmr_state_e;

  localparam logic [1:0] TMR_ONESHOT = 2'b00;
  localparam logic [1:0] TMR_RELOAD  = 2'b01;

  // Lane i takes new_v when be[i] is set, otherwise keeps old_v.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped countdown timer responder with interrupt output
//
// Purpose: CPU data-bus responder with CTRL/PRESET/COUNT registers and a
// countdown FSM that raises an interrupt on expiry.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   addr   : data-bus byte address
//   byteen : write byte enables (nonzero = write)
//   wdata  : lane-aligned write data
//   rdata  : combinational read data (0 when not hit)
//   hit    : address decodes to CTRL, PRESET or COUNT
//   irq    : interrupt request, CTRL.IM & irq flag
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  logic [3:0]  ctrl_q,   ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q,  count_d;
  logic        flag_q,   flag_d;
  tmr_state_e  state_q,  state_d;

  logic       en;
  logic [1:0] mode;
  logic       im;
  logic       wr;
  logic       wr_ctrl;
  logic       wr_preset;
  logic       unused_addr_lsb;

  assign en   = ctrl_q[0];
  assign mode = ctrl_q[2:1];
  assign im   = ctrl_q[3];

  // Word-aligned decode; the byte offset within a word is irrelevant.
  assign unused_addr_lsb = ^addr[1:0];

  assign hit       = (addr[31:4] == BASE[31:4]) && (addr[3:2] != 2'b11);
  assign wr        = hit && (byteen != 4'b0000);
  assign wr_ctrl   = wr && (addr[3:2] == TMR_CTRL);
  assign wr_preset = wr && (addr[3:2] == TMR_PRESET);

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (addr[3:2])
        TMR_CTRL:   rdata = {28'd0, ctrl_q};
        TMR_PRESET: rdata = preset_q;
        TMR_COUNT:  rdata = count_q;
        default:    rdata = 32'd0;
      endcase
    end
  end

  assign irq = im & flag_q;

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    state_d  = state_q;

    case (state_q)
      TMR_IDLE: begin
        if (en) state_d = TMR_LOAD;
      end
      TMR_LOAD: begin
        count_d = preset_q;
        flag_d  = 1'b0;
        state_d = TMR_CNT;
      end
      TMR_CNT: begin
        if (!en) begin
          state_d = TMR_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = TMR_INT;
        end
      end
      TMR_INT: begin
        flag_d = 1'b1;
        if (mode == TMR_RELOAD) begin
          state_d = TMR_LOAD;
        end else begin
          // MODE 00 and 1x both behave as one-shot.
          ctrl_d[0] = 1'b0;
          state_d   = TMR_IDLE;
        end
      end
      default: state_d = TMR_IDLE;
    endcase

    // Bus writes are applied last so they override the FSM's EN clear
    // and flag update in the same cycle.
    if (wr_ctrl) begin
      if (byteen[0]) ctrl_d = wdata[3:0];
      flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = lane_merge(preset_q, wdata, byteen);
      flag_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
      state_q  <= TMR_IDLE;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// tb/tb_bus_timer.sv - self-checking testbench for bus_timer
module tb_bus_timer;

  localparam logic [31:0] BASE  = 32'h0000_7f00;
  localparam logic [31:0] A_CTL = BASE + 32'h0;
  localparam logic [31:0] A_PRE = BASE + 32'h4;
  localparam logic [31:0] A_CNT = BASE + 32'h8;
  localparam logic [31:0] A_GAP = BASE + 32'hC;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  int vectors;
  int miscompares;

  bus_timer #(.BASE(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .hit    (hit),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Stimulus helpers (no checking inside).
  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    byteen = 4'd0;
    addr   = 32'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Commits a write on the next rising edge; returns 1ns after that edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr   = a;
    wdata  = d;
    byteen = be;
    @(posedge clk);
    #1;
    byteen = 4'd0;
    addr   = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: COUNT value after edge k (k>=2) for a timer enabled at edge 0.
  function automatic logic [31:0] model_count(input int n, input int k, input int period);
    int j;
    j = (period > 0) ? (k - 2) % period : (k - 2);
    return (n > j) ? 32'(n - j) : 32'd0;
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    rd(A_CTL, v);
    vectors++;
    if (v !== 32'd0) begin $display("FAIL reset_ctrl: got %h want %h", v, 32'd0); miscompares++; end
    rd(A_PRE, v);
    vectors++;
    if (v !== 32'd0) begin $display("FAIL reset_preset: got %h want %h", v, 32'd0); miscompares++; end
    vectors++;
    if (irq !== 1'b0) begin $display("FAIL reset_irq: got %b want 0", irq); miscompares++; end

    // Asynchronous reset mid-count with COUNT=5.
    bus_write(A_PRE, 32'd10, 4'hF);
    bus_write(A_CTL, 32'h9, 4'hF);
    step(7);
    rd(A_CNT, v);
    vectors++;
    if (v !== 32'd5) begin $display("FAIL premid_count: got %0d want 5", v); miscompares++; end
    #1;
    reset = 1'b0;
    #1;
    rd(A_CNT, v);
    vectors++;
    if (v !== 32'd0) begin $display("FAIL async_count: got %0d want 0", v); miscompares++; end
    rd(A_CTL, v);
    vectors++;
    if (v !== 32'd0) begin $display("FAIL async_ctrl: got %h want 0", v); miscompares++; end
    rd(A_PRE, v);
    vectors++;
    if (v !== 32'd0) begin $display("FAIL async_preset: got %h want 0", v); miscompares++; end
    vectors++;
    if (irq !== 1'b0) begin $display("FAIL async_irq: got %b want 0", irq); miscompares++; end
    vectors++;
    if (hit !== 1'b1) begin $display("FAIL async_hit: got %b want 1", hit); miscompares++; end
    @(negedge clk);
    reset = 1'b1;
    step(4);
    rd(A_CNT, v);
    vectors++;
    if (v !== 32'd0) begin $display("FAIL post_reset_idle_count: got %0d want 0", v); miscompares++; end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    int          n;
    int          t;
    logic [1:0]  md;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n  = (it == 0) ? 3 : int'($urandom_range(0, 6));
      md = (it == 0) ? 2'b00 : ((($urandom_range(0, 2)) == 0) ? 2'b00 : ((($urandom_range(0, 1)) == 0) ? 2'b10 : 2'b11));
      t  = ((n > 1) ? n : 1) + 3;
      bus_write(A_PRE, 32'(n), 4'hF);
      bus_write(A_CTL, {28'd0, 1'b1, md, 1'b1}, 4'hF);
      for (int k = 1; k <= t + 2; k++) begin
        step(1);
        vectors++;
        if (irq !== (k >= t)) begin
          $display("FAIL oneshot_irq n=%0d edge=%0d: got %b want %b", n, k, irq, (k >= t));
          miscompares++;
        end
        if (k >= 2) begin
          rd(A_CNT, v);
          vectors++;
          if (v !== model_count(n, k, 0)) begin
            $display("FAIL oneshot_count n=%0d edge=%0d: got %0d want %0d", n, k, v, model_count(n, k, 0));
            miscompares++;
          end
        end
      end
      rd(A_CTL, v);
      vectors++;
      if (v !== {28'd0, 1'b1, md, 1'b0}) begin
        $display("FAIL oneshot_ctrl: got %h want %h", v, {28'd0, 1'b1, md, 1'b0});
        miscompares++;
      end
      bus_write(A_CTL, 32'h8, 4'hF);
      vectors++;
      if (irq !== 1'b0) begin $display("FAIL oneshot_clear_irq: got %b want 0", irq); miscompares++; end
    end
  endtask

  task automatic test_reload();
    logic [31:0] v;
    int          n;
    int          t;
    int          p;
    logic        exp_irq;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      n = (it == 0) ? 2 : int'($urandom_range(0, 5));
      t = ((n > 1) ? n : 1) + 3;
      p = ((n > 1) ? n : 1) + 2;
      bus_write(A_PRE, 32'(n), 4'hF);
      bus_write(A_CTL, 32'hB, 4'hF);
      for (int k = 1; k <= t + 3 * p; k++) begin
        step(1);
        exp_irq = (k >= t) && (((k - t) % p) == 0);
        vectors++;
        if (irq !== exp_irq) begin
          $display("FAIL reload_irq n=%0d edge=%0d: got %b want %b", n, k, irq, exp_irq);
          miscompares++;
        end
        if (k >= 2) begin
          rd(A_CNT, v);
          vectors++;
          if (v !== model_count(n, k, p)) begin
            $display("FAIL reload_count n=%0d edge=%0d: got %0d want %0d", n, k, v, model_count(n, k, p));
            miscompares++;
          end
        end
      end
    end
  endtask

  task automatic test_byteen();
    logic [31:0] v;
    logic [31:0] o;
    logic [31:0] nw;
    logic [3:0]  be;
    logic [31:0] m;
    do_reset();
    bus_write(A_PRE, 32'h1122_3344, 4'hF);
    bus_write(A_PRE, 32'hAABB_CCDD, 4'b0101);
    rd(A_PRE, v);
    vectors++;
    if (v !== 32'h11BB_33DD) begin $display("FAIL byteen_fixed: got %h want %h", v, 32'h11BB_33DD); miscompares++; end
    for (int it = 0; it < 6; it++) begin
      o  = $urandom;
      nw = $urandom;
      be = 4'($urandom_range(1, 15));
      m  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      bus_write(A_PRE, o, 4'hF);
      bus_write(A_PRE, nw, be);
      rd(A_PRE, v);
      vectors++;
      if (v !== ((o & ~m) | (nw & m))) begin
        $display("FAIL byteen_rand be=%b: got %h want %h", be, v, (o & ~m) | (nw & m));
        miscompares++;
      end
    end
    // Freeze COUNT at 5, then a write to COUNT must not change it.
    do_reset();
    bus_write(A_PRE, 32'd7, 4'hF);
    bus_write(A_CTL, 32'h1, 4'hF);
    step(3);
    bus_write(A_CTL, 32'h0, 4'hF);
    step(2);
    bus_write(A_CNT, 32'hFFFF_FFFF, 4'hF);
    rd(A_CNT, v);
    vectors++;
    if (v !== 32'd5) begin $display("FAIL count_readonly: got %0d want 5", v); miscompares++; end
    bus_write(A_CTL, 32'hFFFF_FFF0, 4'hF);
    rd(A_CTL, v);
    vectors++;
    if (v !== 32'd0) begin $display("FAIL ctrl_upper_bits: got %h want 0", v); miscompares++; end
  endtask

  task automatic test_mask_decode();
    logic [31:0] v;
    do_reset();
    bus_write(A_PRE, 32'd2, 4'hF);
    bus_write(A_CTL, 32'h1, 4'hF);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      vectors++;
      if (irq !== 1'b0) begin $display("FAIL masked_irq edge=%0d: got %b want 0", k, irq); miscompares++; end
    end
    rd(A_CTL, v);
    vectors++;
    if (v !== 32'd0) begin $display("FAIL masked_ctrl: got %h want 0", v); miscompares++; end
    bus_write(A_CTL, 32'h8, 4'hF);
    step(1);
    vectors++;
    if (irq !== 1'b0) begin $display("FAIL unmask_after_clear: got %b want 0", irq); miscompares++; end

    bus_write(A_PRE, 32'h1234_5678, 4'hF);
    bus_write(A_GAP, 32'hDEAD_BEEF, 4'hF);
    rd(A_GAP, v);
    vectors++;
    if (hit !== 1'b0) begin $display("FAIL gap_hit: got %b want 0", hit); miscompares++; end
    vectors++;
    if (v !== 32'd0) begin $display("FAIL gap_rdata: got %h want 0", v); miscompares++; end
    rd(BASE + 32'h10, v);
    vectors++;
    if (hit !== 1'b0 || v !== 32'd0) begin $display("FAIL outside_decode: hit=%b rdata=%h want hit=0 rdata=0", hit, v); miscompares++; end
    rd(A_PRE + 32'h2, v);
    vectors++;
    if (hit !== 1'b1 || v !== 32'h1234_5678) begin
      $display("FAIL preset_after_gap_write: hit=%b rdata=%h want hit=1 rdata=%h", hit, v, 32'h1234_5678);
      miscompares++;
    end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    do_reset();
    bus_write(A_PRE, 32'd2, 4'hF);
    bus_write(A_CTL, 32'h1, 4'hF);
    step(4);
    // This write commits on edge 5, the INT cycle of the one-shot.
    bus_write(A_CTL, 32'h1, 4'hF);
    rd(A_CTL, v);
    vectors++;
    if (v !== 32'd1) begin $display("FAIL priority_ctrl: got %h want 1", v); miscompares++; end
    step(2);
    rd(A_CNT, v);
    vectors++;
    if (v !== 32'd2) begin $display("FAIL priority_reload_count: got %0d want 2", v); miscompares++; end
    step(1);
    rd(A_CNT, v);
    vectors++;
    if (v !== 32'd1) begin $display("FAIL priority_count_dec: got %0d want 1", v); miscompares++; end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    addr        = 32'd0;
    byteen      = 4'd0;
    wdata       = 32'd0;
    test_reset();
    test_oneshot();
    test_reload();
    test_byteen();
    test_mask_decode();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
